// File: rtl/fft_pkg.sv
// Shared widths and types for the I2S-to-FFT sample path.
package fft_pkg;

  localparam int SAMPLE_W = 24;
  localparam int FFT_W    = 32;
  localparam int DROP_W   = 16;

  typedef enum logic {
    WAIT = 1'b0,
    FILL = 1'b1
  } framer_state_t;

  // FFT input word: 24-bit sample left-justified in 32 bits.
  function automatic logic [FFT_W-1:0] pack_fft(input logic [SAMPLE_W-1:0] s);
    return {s, 8'd0};
  endfunction

endpackage

// File: rtl/i2s_sample_framer_boxcar_decim.sv
// Boxcar decimator: sums DECIM signed samples and emits their floored mean.
module boxcar_decim
  import fft_pkg::*;
#(
  parameter int DECIM = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  input  logic [SAMPLE_W-1:0] in,
  output logic                out_valid,
  output logic [SAMPLE_W-1:0] out
);

  localparam int SHIFT = $clog2(DECIM);
  localparam int ACC_W = SAMPLE_W + SHIFT;
  localparam int PH_W  = SHIFT + 1;

  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [ACC_W-1:0] sum_s;
  logic [PH_W-1:0]         phase_q, phase_d;
  logic                    out_valid_q, out_valid_d;
  logic [SAMPLE_W-1:0]     out_q, out_d;

  // Next-state: accumulate, and on the DECIM-th sample shift out the mean.
  always_comb begin
    sum_s = acc_q + ACC_W'(signed'(in));
    if (in_valid) begin
      if (phase_q == PH_W'(DECIM - 1)) begin
        out_valid_d = 1'b1;
        out_d       = SAMPLE_W'(sum_s >>> SHIFT);
        acc_d       = '0;
        phase_d     = '0;
      end else begin
        out_valid_d = 1'b0;
        out_d       = out_q;
        acc_d       = sum_s;
        phase_d     = phase_q + {{(PH_W-1){1'b0}}, 1'b1};
      end
    end else begin
      out_valid_d = 1'b0;
      out_d       = out_q;
      acc_d       = acc_q;
      phase_d     = phase_q;
    end
  end

  // Accumulator, phase and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q       <= '0;
      phase_q     <= '0;
      out_valid_q <= 1'b0;
      out_q       <= '0;
    end else begin
      acc_q       <= acc_d;
      phase_q     <= phase_d;
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out       = out_q;

endmodule

// File: rtl/i2s_sample_framer.sv
// Bridges I2S left words into the clk domain, decimates them and packs
// the result into gapless N-sample FFT frames gated by fft_ready_i.
module i2s_sample_framer
  import fft_pkg::*;
#(
  parameter int DECIM = 4,
  parameter int N     = 256
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                lrck_i,
  input  logic [SAMPLE_W-1:0] left_i,
  input  logic                fft_ready_i,
  output logic [FFT_W-1:0]    sample_o,
  output logic                sample_valid_o,
  output logic                frame_start_o,
  output logic                frame_last_o,
  output logic [DROP_W-1:0]   drop_cnt_o
);

  localparam int CNT_W = $clog2(N + 1);

  logic                s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
  logic                fall_s;
  logic [SAMPLE_W-1:0] raw_q, raw_d;
  logic                raw_valid_q, raw_valid_d;
  logic                dec_valid_s;
  logic [SAMPLE_W-1:0] dec_data_s;

  framer_state_t       state_q, state_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [DROP_W-1:0]   drop_cnt_q, drop_cnt_d;
  logic [FFT_W-1:0]    sample_q, sample_d;
  logic                valid_q, valid_d;
  logic                start_q, start_d;
  logic                last_q, last_d;

  // Every LRCK fall marks a complete left word; a 0 reset value means LRCK
  // has to be seen high before a fall can count, so no edge appears at release.
  assign fall_s = s3_q & ~s2_q;

  // Sync chain and capture of the quasi-static left word.
  always_comb begin
    s1_d        = lrck_i;
    s2_d        = s1_q;
    s3_d        = s2_q;
    raw_valid_d = fall_s;
    if (fall_s) begin
      raw_d = left_i;
    end else begin
      raw_d = raw_q;
    end
  end

  // LRCK synchroniser and raw sample registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q        <= 1'b0;
      s2_q        <= 1'b0;
      s3_q        <= 1'b0;
      raw_q       <= '0;
      raw_valid_q <= 1'b0;
    end else begin
      s1_q        <= s1_d;
      s2_q        <= s2_d;
      s3_q        <= s3_d;
      raw_q       <= raw_d;
      raw_valid_q <= raw_valid_d;
    end
  end

  boxcar_decim #(
    .DECIM(DECIM)
  ) u_decim (
    .clk      (clk),
    .reset    (reset),
    .in_valid (raw_valid_q),
    .in       (raw_q),
    .out_valid(dec_valid_s),
    .out      (dec_data_s)
  );

  // Framer next-state: fft_ready_i only matters when a frame would start.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    drop_cnt_d = drop_cnt_q;
    sample_d   = sample_q;
    valid_d    = 1'b0;
    start_d    = 1'b0;
    last_d     = 1'b0;
    case (state_q)
      WAIT: begin
        if (dec_valid_s) begin
          if (fft_ready_i) begin
            sample_d = pack_fft(dec_data_s);
            valid_d  = 1'b1;
            start_d  = 1'b1;
            count_d  = CNT_W'(1);
            state_d  = FILL;
          end else if (drop_cnt_q != 16'hFFFF) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
          end else begin
            drop_cnt_d = drop_cnt_q;
          end
        end else begin
          state_d = WAIT;
        end
      end
      FILL: begin
        if (dec_valid_s) begin
          sample_d = pack_fft(dec_data_s);
          valid_d  = 1'b1;
          if (count_q == CNT_W'(N - 1)) begin
            last_d  = 1'b1;
            count_d = '0;
            state_d = WAIT;
          end else begin
            count_d = count_q + CNT_W'(1);
          end
        end else begin
          state_d = FILL;
        end
      end
      default: begin
        state_d = WAIT;
        count_d = '0;
      end
    endcase
  end

  // Framer state, drop counter and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= WAIT;
      count_q    <= '0;
      drop_cnt_q <= '0;
      sample_q   <= '0;
      valid_q    <= 1'b0;
      start_q    <= 1'b0;
      last_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      drop_cnt_q <= drop_cnt_d;
      sample_q   <= sample_d;
      valid_q    <= valid_d;
      start_q    <= start_d;
      last_q     <= last_d;
    end
  end

  assign sample_o       = sample_q;
  assign sample_valid_o = valid_q;
  assign frame_start_o  = start_q;
  assign frame_last_o   = last_q;
  assign drop_cnt_o     = drop_cnt_q;

endmodule

// File: tb/tb_i2s_sample_framer.sv
// Directed bench for i2s_sample_framer (DECIM=4, N=8) with a scoreboard queue.
module tb_i2s_sample_framer;

  localparam int DECIM = 4;
  localparam int N     = 8;
  localparam int HALF  = 16;

  typedef struct {
    logic [31:0] sample;
    logic        start;
    logic        last;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        lrck = 1'b0;
  logic [23:0] left = 24'd0;
  logic        ready = 1'b0;
  logic [31:0] sample_o;
  logic        sample_valid_o;
  logic        frame_start_o;
  logic        frame_last_o;
  logic [15:0] drop_cnt_o;

  int   cyc = 0;
  int   n_assert = 0;
  int   n_fail = 0;
  exp_t q[$];
  exp_t got;

  int   bsum = 0;
  int   bph = 0;
  int   mcount = 0;
  int   mdrop = 0;
  bit   mfill = 1'b0;

  i2s_sample_framer #(.DECIM(DECIM), .N(N)) dut (
    .clk           (clk),
    .reset         (reset),
    .lrck_i        (lrck),
    .left_i        (left),
    .fft_ready_i   (ready),
    .sample_o      (sample_o),
    .sample_valid_o(sample_valid_o),
    .frame_start_o (frame_start_o),
    .frame_last_o  (frame_last_o),
    .drop_cnt_o    (drop_cnt_o)
  );

  always #10 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Model of decimator + framer, fed with each raw word at its LRCK fall.
  task automatic model_raw(input logic [23:0] d, input int fall_cyc);
    int   avg;
    exp_t e;
    bsum = bsum + $signed(d);
    bph++;
    if (bph == DECIM) begin
      avg  = bsum >>> $clog2(DECIM);
      bsum = 0;
      bph  = 0;
      e.sample = {avg[23:0], 8'h00};
      e.due    = fall_cyc + 5;
      e.start  = 1'b0;
      e.last   = 1'b0;
      if (!mfill) begin
        if (ready) begin
          e.start = 1'b1;
          mcount  = 1;
          mfill   = 1'b1;
          q.push_back(e);
        end else if (mdrop < 65535) begin
          mdrop++;
        end
      end else begin
        mcount++;
        if (mcount == N) begin
          e.last = 1'b1;
          mfill  = 1'b0;
          mcount = 0;
        end
        q.push_back(e);
      end
    end
  endtask

  // One LRCK period: word changes at the rise, DUT captures after the fall.
  task automatic lrck_frame(input logic [23:0] d);
    @(negedge clk);
    lrck = 1'b1;
    left = d;
    repeat (HALF - 1) @(negedge clk);
    lrck = 1'b0;
    model_raw(d, cyc);
    repeat (HALF - 1) @(negedge clk);
  endtask

  task automatic apply_reset(input logic lrck_level, input string tag);
    @(negedge clk);
    lrck  = lrck_level;
    reset = 1'b1;
    #1;
    check({tag, "_sample"}, sample_o, 32'h0);
    check({tag, "_valid"}, {31'd0, sample_valid_o}, 32'h0);
    check({tag, "_start"}, {31'd0, frame_start_o}, 32'h0);
    check({tag, "_last"}, {31'd0, frame_last_o}, 32'h0);
    check({tag, "_drop"}, {16'd0, drop_cnt_o}, 32'h0);
    q.delete();
    bsum = 0; bph = 0; mcount = 0; mdrop = 0; mfill = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b0;
  endtask

  // Scoreboard: pop on every valid strobe; flag missing or surplus strobes.
  always @(negedge clk) begin
    if (sample_valid_o) begin
      if (q.size() == 0) begin
        check("unexpected_valid", 32'd1, 32'd0);
      end else begin
        got = q.pop_front();
        check("sample", sample_o, got.sample);
        check("frame_start", {31'd0, frame_start_o}, {31'd0, got.start});
        check("frame_last", {31'd0, frame_last_o}, {31'd0, got.last});
        check("latency_cycle", cyc, got.due);
      end
    end else if (q.size() > 0 && cyc > q[0].due) begin
      check("missing_valid", 32'd0, 32'd1);
      void'(q.pop_front());
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_sample", sample_o, 32'h0);
    check("rst_valid", {31'd0, sample_valid_o}, 32'h0);
    check("rst_start", {31'd0, frame_start_o}, 32'h0);
    check("rst_last", {31'd0, frame_last_o}, 32'h0);
    check("rst_drop", {16'd0, drop_cnt_o}, 32'h0);
    reset = 1'b0;
    repeat (4) @(negedge clk);

    // Repeated identical words: full frame, then the next frame starts at once.
    ready = 1'b1;
    for (int i = 0; i < 9 * DECIM; i++) lrck_frame(24'h100000);

    // Rounding: positive mean and floored negative mean.
    lrck_frame(24'd4); lrck_frame(24'd8); lrck_frame(24'd12); lrck_frame(24'd16);
    lrck_frame(24'hFFFFFD); lrck_frame(24'hFFFFFD);
    lrck_frame(24'hFFFFFD); lrck_frame(24'hFFFFFE);

    // Ready drops mid-frame: the frame still completes.
    ready = 1'b0;
    for (int i = 0; i < 5 * DECIM; i++) lrck_frame(24'h012345);

    // Not ready between frames: five decimated samples dropped.
    for (int i = 0; i < 5 * DECIM; i++) lrck_frame(24'h222222);
    check("drop_cnt_5", {16'd0, drop_cnt_o}, 32'd5);
    check("drop_cnt_model", {16'd0, drop_cnt_o}, mdrop);
    ready = 1'b1;
    for (int i = 0; i < 5 * DECIM; i++) lrck_frame(24'h0ABCDE);
    lrck_frame(24'h7FFFFF);
    lrck_frame(24'h7FFFFF);

    // Reset mid-frame with a half-filled accumulator, LRCK low through release.
    apply_reset(1'b0, "midframe_rst");
    repeat (20) @(negedge clk);
    for (int i = 0; i < DECIM; i++) lrck_frame(24'h000040);

    // Reset with LRCK held high: first fall after release is a real word.
    apply_reset(1'b1, "high_rst");
    repeat (6) @(negedge clk);
    for (int i = 0; i < 2 * DECIM; i++) lrck_frame(24'hFFFFF8);

    repeat (20) @(negedge clk);
    check("queue_drained", q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/i2s_sample_framer.md
# i2s_sample_framer

Clock-domain bridge, decimator and frame builder between the I2S receiver and the FFT core. Detects each left-channel word from the BCK-domain receiver in the 48 MHz `clk` domain and averages DECIM consecutive samples (boxcar). Delivers decimated samples to the FFT in gapless frames of N, starting a frame only when the FFT reports ready. Replaces the value-change `sample_valid` detection, which misses repeated equal samples.

## Interface
- `DECIM`, 4: decimation factor; power of two, 1..16.
- `N`, 256: samples per FFT frame; 2..1024.
- `clk`  in  1  48 MHz system clock.
- `reset`  in  1  asynchronous, active-high.
- `lrck_i`  in  1  I2S LRCK, asynchronous to `clk`.
- `left_i`  in  24  signed left word, BCK domain. Updates at LRCK rising edge; stable ≥ 1 frame afterwards.
- `fft_ready_i`  in  1  FFT can accept a full frame; sampled only at frame start.
- `sample_o`  out  32  `{avg24, 8'd0}`.
- `sample_valid_o`  out  1  one-cycle strobe qualifying `sample_o`.
- `frame_start_o`  out  1  with first valid of a frame.
- `frame_last_o`  out  1  with Nth valid of a frame.
- `drop_cnt_o`  out  16  decimated samples discarded while waiting; saturating.

## Operation
- LRCK sync: 2 flops (`s1`, `s2`) plus history flop `s3`, all reset to 0. A falling edge is `s3 & ~s2`. Reset value 0 prevents a spurious edge: LRCK must be seen high, then low.
- Capture: on a falling-edge pulse, register `left_i` into `raw` (quasi-static mid-frame; no further sync).
- Decimator: signed accumulator of width 24+log2(DECIM) and phase counter of width log2(DECIM)+1.
  - Each `raw` adds to the accumulator. On the DECIM-th add, `avg24 = (acc + raw) >>> log2(DECIM)` (arithmetic, floor), accumulator cleared, phase reset.
  - DECIM=1 is a pass-through.
- Framer FSM:
  - WAIT: on decimated sample, if `fft_ready_i`=1, emit it with `frame_start_o`, set count=1, go FILL. Otherwise drop it and increment `drop_cnt_o` (saturate at 16'hFFFF).
  - FILL: emit every decimated sample regardless of `fft_ready_i`, count++. On the Nth sample assert `frame_last_o` and go WAIT.
  - WAIT can start a new frame on the very next decimated sample.
- Reset (any time, including mid-frame): all outputs 0, FSM=WAIT, count=0, accumulator and phase 0, `drop_cnt_o`=0. After release, the first output needs DECIM fresh raw samples; the next frame begins with `frame_start_o`.

## Timing
- Let E be the `clk` edge at which `s1` first samples `lrck_i` low.
  - E+1: `s2` low.
  - E+2: `raw` captured.
  - E+3: accumulate.
  - E+4: `sample_o`, `sample_valid_o`, `frame_start_o`, `frame_last_o` registered.
- Latency: 4 `clk` cycles, pipelined.
- Strobes are one cycle wide. `sample_o` holds until the next valid.
- Decimated output rate is 48 kHz/DECIM, so ≥ 999 cycles between strobes. No backpressure inside a frame.
- `frame_start_o` and `frame_last_o` are never both high unless N=1 (disallowed).

## Structure
- Shared package `fft_pkg`:
  - `SAMPLE_W`=24, `FFT_W`=32.
  - `framer_state_t` enum {WAIT, FILL}.
- One sub-module, `boxcar_decim`: parameterized accumulator, phase counter and shift. Interface: `in_valid`/`in[23:0]` → `out_valid`/`out[23:0]`.
- Top: sync and edge detection, capture, framer FSM, drop counter.
- Target 150–250 RTL lines.

## Test plan
- Use DECIM=4, N=8, LRCK at 48 kHz, `left_i` updated on LRCK rise.
1. Constant 24'h100000, ready=1 → every 4th LRCK fall gives `sample_o`=32'h10000000. `frame_start_o` on 1st valid, `frame_last_o` on 8th, next frame starts on 9th.
2. Inputs 4, 8, 12, 16 → 32'h00000A00. Inputs −3, −3, −3, −2 → avg −3 → 32'hFFFFFD00. Each valid exactly 4 cycles after E of the 4th sample.
3. Ready=0 across 5 decimated samples → no valids, `drop_cnt_o`=5. Raise ready → next sample has `frame_start_o`.
4. Ready drops after frame_start → all 8 samples still emitted, `frame_last_o` on 8th. Next frame waits for ready.
5. Reset asserted after 5th sample of a frame → all outputs 0 immediately. After release, first valid follows 4 new LRCK falls, with `frame_start_o`.
6. `lrck_i` low through reset release → no capture until LRCK goes high then low. Repeated identical samples produce a valid every DECIM frames (no missed strobes).
